// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup, per-way saturating
// direction counters, and round-robin replacement that only advances on eviction.
module btb_assoc #(
  parameter int SET_BITS = 4,
  parameter int WAYS     = 2,
  parameter int PC_BITS  = 11,
  parameter int CTR_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] pc_fetch,
  output logic               hit,
  output logic               pred_taken,
  output logic [PC_BITS-1:0] pc_target_prediction,
  input  logic               upd_en,
  input  logic [PC_BITS-1:0] upd_pc,
  input  logic [PC_BITS-1:0] upd_target,
  input  logic               upd_taken,
  input  logic               flush
);

  localparam int SETS     = 1 << SET_BITS;
  localparam int TAG_BITS = PC_BITS - SET_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_BITS-1:0] CTR_ZERO = CTR_BITS'(0);
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'((2 ** CTR_BITS) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [WAY_BITS-1:0] WAY_ZERO = WAY_BITS'(0);
  localparam logic [WAY_BITS-1:0] WAY_ONE  = WAY_BITS'(1);
  localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);

  logic                valid_r  [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_r    [SETS][WAYS];
  logic [PC_BITS-1:0]  target_r [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_r    [SETS][WAYS];
  logic [WAY_BITS-1:0] ptr_r    [SETS];

  // Lowest set bit wins, so duplicate tag matches resolve to the lowest way.
  function automatic logic [WAY_BITS-1:0] lowest_way(input logic [WAYS-1:0] vec);
    lowest_way = WAY_ZERO;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vec[w]) begin
        lowest_way = WAY_BITS'(w);
      end else begin
        lowest_way = lowest_way;
      end
    end
  endfunction

  logic [SET_BITS-1:0] fetch_set_s;
  logic [TAG_BITS-1:0] fetch_tag_s;
  logic [WAYS-1:0]     fetch_match_s;
  logic [WAY_BITS-1:0] fetch_way_s;
  logic [SET_BITS-1:0] upd_set_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic [WAYS-1:0]     upd_match_s;
  logic [WAYS-1:0]     upd_free_s;
  logic                upd_hit_s;
  logic [WAY_BITS-1:0] upd_way_s;
  logic [WAY_BITS-1:0] alloc_way_s;
  logic                alloc_evict_s;
  logic [CTR_BITS-1:0] upd_ctr_s;
  logic [CTR_BITS-1:0] upd_ctr_next_s;
  logic                do_update_s;

  assign fetch_set_s = pc_fetch[SET_BITS-1:0];
  assign fetch_tag_s = pc_fetch[PC_BITS-1:SET_BITS];
  assign upd_set_s   = upd_pc[SET_BITS-1:0];
  assign upd_tag_s   = upd_pc[PC_BITS-1:SET_BITS];

  // Per-way tag compare for both the fetch port and the update port.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      fetch_match_s[w] = valid_r[fetch_set_s][w] && (tag_r[fetch_set_s][w] == fetch_tag_s);
      upd_match_s[w]   = valid_r[upd_set_s][w] && (tag_r[upd_set_s][w] == upd_tag_s);
      upd_free_s[w]    = !valid_r[upd_set_s][w];
    end
  end

  assign fetch_way_s = lowest_way(fetch_match_s);
  assign upd_hit_s   = |upd_match_s;
  assign upd_way_s   = lowest_way(upd_match_s);
  assign do_update_s = upd_en && !flush && !rst;

  // Prediction outputs read the pre-edge contents of the selected way.
  always_comb begin
    hit                  = |fetch_match_s;
    pred_taken           = 1'b0;
    pc_target_prediction = {PC_BITS{1'b0}};
    if (hit) begin
      pred_taken           = ctr_r[fetch_set_s][fetch_way_s][CTR_BITS-1];
      pc_target_prediction = target_r[fetch_set_s][fetch_way_s];
    end else begin
      pred_taken           = 1'b0;
      pc_target_prediction = {PC_BITS{1'b0}};
    end
  end

  // Victim choice: prefer an empty way, otherwise the round-robin pointer.
  always_comb begin
    alloc_evict_s = !(|upd_free_s);
    if (alloc_evict_s) begin
      alloc_way_s = ptr_r[upd_set_s];
    end else begin
      alloc_way_s = lowest_way(upd_free_s);
    end
  end

  // Saturating counter step for the hit way.
  always_comb begin
    upd_ctr_s      = ctr_r[upd_set_s][upd_way_s];
    upd_ctr_next_s = upd_ctr_s;
    if (upd_taken) begin
      if (upd_ctr_s != CTR_MAX) begin
        upd_ctr_next_s = upd_ctr_s + CTR_ONE;
      end else begin
        upd_ctr_next_s = upd_ctr_s;
      end
    end else begin
      if (upd_ctr_s != CTR_ZERO) begin
        upd_ctr_next_s = upd_ctr_s - CTR_ONE;
      end else begin
        upd_ctr_next_s = upd_ctr_s;
      end
    end
  end

  // Valid bits and victim pointers: cleared by reset or flush, set on allocation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_r[s] <= WAY_ZERO;
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
        end
      end
    end else if (upd_en && !upd_hit_s && upd_taken) begin
      valid_r[upd_set_s][alloc_way_s] <= 1'b1;
      if (alloc_evict_s) begin
        ptr_r[upd_set_s] <= (ptr_r[upd_set_s] == WAY_LAST) ? WAY_ZERO
                                                           : ptr_r[upd_set_s] + WAY_ONE;
      end else begin
        ptr_r[upd_set_s] <= ptr_r[upd_set_s];
      end
    end else begin
      ptr_r[upd_set_s] <= ptr_r[upd_set_s];
    end
  end

  // Entry payload; left stale on reset/flush since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_update_s && upd_hit_s) begin
      ctr_r[upd_set_s][upd_way_s] <= upd_ctr_next_s;
      if (upd_taken) begin
        target_r[upd_set_s][upd_way_s] <= upd_target;
      end else begin
        target_r[upd_set_s][upd_way_s] <= target_r[upd_set_s][upd_way_s];
      end
    end else if (do_update_s && upd_taken) begin
      tag_r[upd_set_s][alloc_way_s]    <= upd_tag_s;
      target_r[upd_set_s][alloc_way_s] <= upd_target;
      ctr_r[upd_set_s][alloc_way_s]    <= CTR_WEAK;
    end else begin
      ctr_r[upd_set_s][upd_way_s] <= ctr_r[upd_set_s][upd_way_s];
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Randomized bench for btb_assoc against an array-based model of the BTB rules,
// preceded by directed scenarios for reset, saturation, eviction and flush.
module tb_btb_assoc;

  localparam int SET_BITS = 4;
  localparam int WAYS     = 2;
  localparam int PC_BITS  = 11;
  localparam int CTR_BITS = 2;
  localparam int SETS     = 1 << SET_BITS;
  localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
  localparam int CTR_WEAK = 1 << (CTR_BITS - 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [PC_BITS-1:0] pc_fetch = '0;
  logic               hit;
  logic               pred_taken;
  logic [PC_BITS-1:0] pc_target_prediction;
  logic               upd_en = 1'b0;
  logic [PC_BITS-1:0] upd_pc = '0;
  logic [PC_BITS-1:0] upd_target = '0;
  logic               upd_taken = 1'b0;
  logic               flush = 1'b0;

  always #5 clk = ~clk;

  btb_assoc #(
    .SET_BITS(SET_BITS), .WAYS(WAYS), .PC_BITS(PC_BITS), .CTR_BITS(CTR_BITS)
  ) dut (
    .clk(clk), .rst(rst), .pc_fetch(pc_fetch), .hit(hit), .pred_taken(pred_taken),
    .pc_target_prediction(pc_target_prediction), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush)
  );

  int total = 0;
  int bad   = 0;

  // Reference state, indexed directly by set number and way number.
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_tgt   [SETS][WAYS];
  int m_ctr   [SETS][WAYS];
  int m_ptr   [SETS];

  int obs_hit, obs_pt, obs_tgt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  function automatic int model_find(input int pc);
    int s = pc % SETS;
    int t = pc / SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic model_edge(input bit ue, input int up, input int ut, input bit tk,
                            input bit fl, input bit rs);
    int s, w;
    if (rs || fl) begin
      model_clear();
    end else if (ue) begin
      s = up % SETS;
      w = model_find(up);
      if (w >= 0) begin
        m_ctr[s][w] = tk ? ((m_ctr[s][w] < CTR_MAX) ? m_ctr[s][w] + 1 : CTR_MAX)
                         : ((m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0);
        if (tk) m_tgt[s][w] = ut;
      end else if (tk) begin
        for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
        if (w < 0) begin
          w = m_ptr[s];
          m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = up / SETS;
        m_tgt[s][w]   = ut;
        m_ctr[s][w]   = CTR_WEAK;
      end
    end
  endtask

  // One clock: drive, compare lookup against the model, clock, advance the model.
  task automatic cyc(input int f, input bit ue, input int up, input int ut,
                     input bit tk, input bit fl, input bit rs);
    int w, eh, ep, et;
    pc_fetch = PC_BITS'(f); upd_en = ue; upd_pc = PC_BITS'(up);
    upd_target = PC_BITS'(ut); upd_taken = tk; flush = fl; rst = rs;
    #1;
    w  = model_find(f);
    eh = (w >= 0) ? 1 : 0;
    ep = (w >= 0) ? ((m_ctr[f % SETS][w] >> (CTR_BITS - 1)) & 1) : 0;
    et = (w >= 0) ? m_tgt[f % SETS][w] : 0;
    obs_hit = int'(hit); obs_pt = int'(pred_taken); obs_tgt = int'(pc_target_prediction);
    check_eq("hit", 32'(hit), 32'(eh));
    check_eq("pred_taken", 32'(pred_taken), 32'(ep));
    check_eq("target", 32'(pc_target_prediction), 32'(et));
    @(posedge clk);
    model_edge(ue, up, ut, tk, fl, rs);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    cyc(12'h123, 0, 0, 0, 0, 0, 0);
    check_eq("rst_hit", 32'(obs_hit), 32'd0);
    check_eq("rst_tgt", 32'(obs_tgt), 32'd0);
    check_eq("rst_pt", 32'(obs_pt), 32'd0);

    // Allocation, then counter saturation downward
    cyc(0, 1, 12'h045, 12'h200, 1, 0, 0);
    cyc(12'h045, 0, 0, 0, 0, 0, 0);
    check_eq("alloc_hit", 32'(obs_hit), 32'd1);
    check_eq("alloc_tgt", 32'(obs_tgt), 32'h200);
    check_eq("alloc_pt", 32'(obs_pt), 32'd1);
    for (int i = 0; i < 3; i++) cyc(12'h045, 1, 12'h045, 12'h7ff, 0, 0, 0);
    cyc(12'h045, 0, 0, 0, 0, 0, 0);
    check_eq("sat_hit", 32'(obs_hit), 32'd1);
    check_eq("sat_pt", 32'(obs_pt), 32'd0);
    check_eq("sat_tgt", 32'(obs_tgt), 32'h200);

    // Same-cycle lookup and update return old contents, new ones next cycle
    cyc(12'h045, 1, 12'h045, 12'h300, 1, 0, 0);
    check_eq("bypass_old", 32'(obs_tgt), 32'h200);
    cyc(12'h045, 0, 0, 0, 0, 0, 0);
    check_eq("bypass_new", 32'(obs_tgt), 32'h300);

    // Eviction in set 5, then pointer at way 1 evicts 0x025 next
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 12'h015, 12'h111, 1, 0, 0);
    cyc(0, 1, 12'h025, 12'h222, 1, 0, 0);
    cyc(0, 1, 12'h035, 12'h333, 1, 0, 0);
    cyc(12'h015, 0, 0, 0, 0, 0, 0);
    check_eq("evict_015", 32'(obs_hit), 32'd0);
    cyc(12'h025, 0, 0, 0, 0, 0, 0);
    check_eq("keep_025", 32'(obs_tgt), 32'h222);
    cyc(12'h035, 0, 0, 0, 0, 0, 0);
    check_eq("keep_035", 32'(obs_tgt), 32'h333);
    cyc(0, 1, 12'h055, 12'h555, 1, 0, 0);
    cyc(12'h025, 0, 0, 0, 0, 0, 0);
    check_eq("ptr1_evict_025", 32'(obs_hit), 32'd0);
    cyc(12'h035, 0, 0, 0, 0, 0, 0);
    check_eq("ptr1_keep_035", 32'(obs_hit), 32'd1);

    // Flush beats a same-cycle update
    cyc(0, 1, 12'h077, 12'h0aa, 1, 1, 0);
    cyc(12'h077, 0, 0, 0, 0, 0, 0);
    check_eq("flush_077", 32'(obs_hit), 32'd0);
    cyc(12'h055, 0, 0, 0, 0, 0, 0);
    check_eq("flush_055", 32'(obs_hit), 32'd0);

    // Random traffic over a narrow PC range so sets fill and conflict
    for (int i = 0; i < 4000; i++) begin
      int f, up;
      f  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 95));
      up = ($urandom_range(0, 1) == 0) ? f : int'($urandom_range(0, 95));
      cyc(f, ($urandom_range(0, 9) < 6), up, int'($urandom_range(0, 2047)),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter SET_BITS, default 4, set index width (2**SET_BITS sets).
REQ-002 SHALL have parameter WAYS, default 2, ways per set (1..8).
REQ-003 SHALL have parameter PC_BITS, default 11, word-address PC width (PC[12:2]).
REQ-004 SHALL have parameter CTR_BITS, default 2, saturating direction-counter width (1..4).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pc_fetch  input  PC_BITS  lookup PC.
REQ-008 SHALL have port hit  output  1  lookup tag match on a valid way.
REQ-009 SHALL have port pred_taken  output  1  MSB of hit way's counter, 0 on miss.
REQ-010 SHALL have port pc_target_prediction  output  PC_BITS  stored target of hit way, 0 on miss.
REQ-011 SHALL have port upd_en  input  1  resolved-branch update strobe.
REQ-012 SHALL have port upd_pc  input  PC_BITS  PC of resolved branch.
REQ-013 SHALL have port upd_target  input  PC_BITS  resolved target.
REQ-014 SHALL have port upd_taken  input  1  resolved direction.
REQ-015 SHALL have port flush  input  1  invalidate all entries.

Function
REQ-016 SHALL split any PC into set = PC[SET_BITS-1:0], tag = PC[PC_BITS-1:SET_BITS].
REQ-017 SHALL store per set and way: valid, tag, target, CTR_BITS counter; per set: round-robin victim pointer (clog2(WAYS) bits).
REQ-018 SHALL compute lookup combinationally from pc_fetch and current state: zero-cycle latency.
REQ-019 SHALL, if several valid ways match (illegal), select lowest-index way.
REQ-020 SHALL, on upd_en with hit in set of upd_pc: increment counter if upd_taken, else decrement; saturate at 0 and 2**CTR_BITS-1.
REQ-021 SHALL, on upd_en hit with upd_taken=1, overwrite that way's target with upd_target; upd_taken=0 leaves target unchanged.
REQ-022 SHALL, on upd_en miss with upd_taken=1, allocate: lowest-index invalid way if any, else way at victim pointer.
REQ-023 SHALL write on allocation: valid=1, tag, target=upd_target, counter=2**(CTR_BITS-1) (weakly taken).
REQ-024 SHALL advance the set's victim pointer (modulo WAYS) only when allocation replaced a valid way.
REQ-025 SHALL ignore upd_en miss with upd_taken=0 (no allocation, no state change).
REQ-026 SHALL, on flush=1, clear all valid bits and victim pointers at the next edge; tags/targets/counters may keep stale values.
REQ-027 SHALL give flush priority over a simultaneous upd_en (update dropped).
REQ-028 SHALL, for lookup and update to the same entry in one cycle, return pre-edge contents; new contents visible the cycle after the edge.
REQ-029 SHALL never touch sets other than upd_pc's set on an update.

Reset
REQ-030 SHALL, with rst=1 at a rising edge, clear all valid bits and victim pointers; rst has priority over flush and upd_en.
REQ-031 SHALL drive hit=0, pred_taken=0, pc_target_prediction=0 in the cycle after reset for any pc_fetch.
REQ-032 SHALL require no initial blocks for correct operation; reset mid-operation discards all learned entries.

Verification
REQ-033 SHALL cover: reset, pc_fetch=0x123 -> hit=0, target=0, pred_taken=0.
REQ-034 SHALL cover: update pc=0x045 target=0x200 taken -> next cycle lookup 0x045 gives hit=1, target=0x200, pred_taken=1 (ctr=2).
REQ-035 SHALL cover: three not-taken updates to 0x045 -> ctr 1,0,0 (saturation), pred_taken=0, hit stays 1.
REQ-036 SHALL cover: taken updates 0x015, 0x025, 0x035 (same set 5) -> 0x015 evicted, 0x025/0x035 hit, pointer=1.
REQ-037 SHALL cover: flush and upd_en (0x077 taken) same cycle -> no lookup hits afterward, including 0x077.
REQ-038 SHALL cover: lookup and update of 0x045 in same cycle -> old target that cycle, new target next cycle.
